spike_detect: RTL and testbench
===============================

SPIKE_DETECT -- requirements
Module: spike_detect

Interface
REQ-001 SHALL have parameter BITSIZE, default 12, width of sample data (offset-binary, midscale 2^(BITSIZE-1)).
REQ-002 SHALL have parameter REFRACT, default 16, refractory length in valid samples (0..255).
REQ-003 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port EN  input  1  block enable; low forces IDLE.
REQ-006 SHALL have port DATA_IN  input  BITSIZE  filtered sample from the upstream moving-average stage.
REQ-007 SHALL have port DATA_VALID  input  1  one-cycle strobe qualifying DATA_IN.
REQ-008 SHALL have port THRESHOLD  input  BITSIZE-1  unsigned magnitude threshold, sampled with each valid sample.
REQ-009 SHALL have port SPIKE_FLAG  output  1  one-cycle pulse per detected spike.
REQ-010 SHALL have port SPIKE_TS  output  16  sample index of the triggering sample, held until the next spike.
REQ-011 SHALL have port PEAK_OUT  output  BITSIZE-1  peak magnitude of the last completed event.
REQ-012 SHALL have port BUSY  output  1  high in EVENT or DEAD.

Function
REQ-013 SHALL register the magnitude on every valid sample: |DATA_IN - 2^(BITSIZE-1)|; DATA_IN=0 saturates to 2^(BITSIZE-1)-1.
REQ-014 SHALL run a sample counter that increments on each DATA_VALID while EN=1, starts at 0, and wraps from 0xFFFF to 0.
REQ-015 SHALL implement FSM states IDLE, ARMED, EVENT, DEAD; from any state, EN=0 goes to IDLE on the next edge and clears the sample counter and refractory counter.
REQ-016 SHALL move IDLE->ARMED on the first edge with EN=1.
REQ-017 SHALL, in ARMED, treat a valid sample with magnitude > THRESHOLD (strict) as a spike: go to EVENT, assert SPIKE_FLAG, and latch SPIKE_TS with that sample's index.
REQ-018 SHALL assert SPIKE_FLAG in cycle n+2 for a DATA_VALID in cycle n, for exactly one cycle.
REQ-019 SHALL stay in EVENT while valid samples exceed THRESHOLD; on the first valid sample <= THRESHOLD, go to DEAD and load the refractory counter with REFRACT.
REQ-020 SHALL, in DEAD, decrement the refractory counter once per valid sample, never trigger a spike, and go to ARMED when the count reaches 0.
REQ-021 SHALL, with REFRACT=0, go directly EVENT->ARMED.
REQ-022 SHALL ignore a DATA_VALID that coincides with EN=0: no count, no state change.
REQ-023 SHALL ignore cycles without DATA_VALID for all state transitions.
REQ-024 SHALL allow a valid sample on every cycle (throughput one sample per clock).

Reset
REQ-025 SHALL, while RST=1, asynchronously force state IDLE, SPIKE_FLAG=0, SPIKE_TS=0, PEAK_OUT=0, BUSY=0, and clear all counters and pipeline registers.
REQ-026 SHALL, when reset is asserted mid-event or mid-refractory, discard the event with no SPIKE_FLAG and no PEAK_OUT update.

Configuration
REQ-027 SHALL, with macro SPIKE_DETECT_PEAK_CAPTURE_EN defined, track the maximum magnitude from the EVENT entry sample through the last above-threshold sample.
REQ-028 SHALL, with that macro defined, load the tracked maximum into PEAK_OUT on the EVENT exit edge and hold it until the next event exits.
REQ-029 SHALL, without that macro, drive PEAK_OUT constant 0 and synthesise no peak register.

Verification (BITSIZE=12, midscale 2048, THRESHOLD=100, REFRACT=4)
REQ-030 SHALL check the positive spike: EN=1, valid samples 2048, 2198, 2048 -> one SPIKE_FLAG 2 cycles after the 2198 strobe, SPIKE_TS=1; with the macro, PEAK_OUT=150 after the event exits.
REQ-031 SHALL check the negative spike and the boundary: 1948 (magnitude 100) -> no spike; 1947 -> spike; DATA_IN=0 -> magnitude 2047 and spike.
REQ-032 SHALL check refractory: spike, then 1 below-threshold sample, then 3 above-threshold samples -> no second flag; after 4 DEAD samples, the next above-threshold sample -> second flag.
REQ-033 SHALL check the multi-sample event: 2200, 2300, 2250, 2048 -> a single flag; with the macro, PEAK_OUT=252.
REQ-034 SHALL check reset and enable: RST pulse in DEAD -> all outputs 0, state IDLE; EN dropped with a coincident strobe -> sample ignored; re-enable -> SPIKE_TS restarts from 0.
REQ-035 SHALL check wrap: 65536 valid samples, then a spike -> SPIKE_TS=0.

Source files
------------

// File: rtl/spike_detect.sv
// spike_detect: threshold spike detector with refractory period and optional peak capture.
// Ports: CLK, RST (async, active-high), EN, DATA_IN, DATA_VALID, THRESHOLD in;
//        SPIKE_FLAG, SPIKE_TS, PEAK_OUT, BUSY out.
// Macro SPIKE_DETECT_PEAK_CAPTURE_EN adds the peak register; without it PEAK_OUT is tied to 0.
module spike_detect #(
  parameter int BITSIZE = 12,
  parameter int REFRACT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [BITSIZE-1:0] DATA_IN,
  input  logic               DATA_VALID,
  input  logic [BITSIZE-2:0] THRESHOLD,
  output logic               SPIKE_FLAG,
  output logic [15:0]        SPIKE_TS,
  output logic [BITSIZE-2:0] PEAK_OUT,
  output logic               BUSY
);
  typedef enum logic [1:0] {IDLE, ARMED, EVENT, DEAD} state_t;
  localparam logic [7:0] REFR = 8'(REFRACT);
  state_t state;
  logic [BITSIZE-2:0] low, mag, s1_mag, s1_thr;
  logic [15:0] cnt, s1_idx;
  logic [7:0] refr;
  logic s1_valid, above;
  // Below midscale the distance is 2^(B-1)-low, i.e. -low in B-1 bits; low==0 would overflow, so saturate.
  assign low = DATA_IN[BITSIZE-2:0];
  assign mag = DATA_IN[BITSIZE-1] ? low : (low == '0 ? '1 : -low);
  assign above = s1_mag > s1_thr;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_mag <= '0;
      s1_thr <= '0;
      s1_idx <= '0;
    end else begin
      s1_valid <= EN && DATA_VALID;
      if (!EN) cnt <= '0;
      else if (DATA_VALID) begin
        cnt <= cnt + 16'd1;
        s1_mag <= mag;
        s1_thr <= THRESHOLD;
        s1_idx <= cnt;
      end
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      refr <= '0;
      SPIKE_FLAG <= 1'b0;
      SPIKE_TS <= '0;
      BUSY <= 1'b0;
    end else begin
      SPIKE_FLAG <= 1'b0;
      if (!EN) begin
        state <= IDLE;
        refr <= '0;
        BUSY <= 1'b0;
      end else
        case (state)
          IDLE: state <= ARMED;
          ARMED:
            if (s1_valid && above) begin
              state <= EVENT;
              BUSY <= 1'b1;
              SPIKE_FLAG <= 1'b1;
              SPIKE_TS <= s1_idx;
            end
          EVENT:
            if (s1_valid && !above) begin
              state <= (REFRACT == 0) ? ARMED : DEAD;
              BUSY <= REFRACT != 0;
              refr <= REFR;
            end
          DEAD:
            if (s1_valid) begin
              refr <= refr - 8'd1;
              if (refr == 8'd1) begin
                state <= ARMED;
                BUSY <= 1'b0;
              end
            end
          default: state <= IDLE;
        endcase
    end
`ifdef SPIKE_DETECT_PEAK_CAPTURE_EN
  logic [BITSIZE-2:0] peak;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      peak <= '0;
      PEAK_OUT <= '0;
    end else if (EN && s1_valid) begin
      if (state == ARMED && above) peak <= mag_q();
      else if (state == EVENT && above && s1_mag > peak) peak <= s1_mag;
      else if (state == EVENT && !above) PEAK_OUT <= peak;
    end
  function automatic logic [BITSIZE-2:0] mag_q();
    return s1_mag;
  endfunction
`else
  assign PEAK_OUT = '0;
`endif
endmodule

// File: tb/tb_spike_detect.sv
// tb_spike_detect: randomized and directed self-checking bench for spike_detect against a sample-level model.
module tb_spike_detect;
  localparam int B = 12;
  localparam int R = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN = 1'b0;
  logic DATA_VALID = 1'b0;
  logic [B-1:0] DATA_IN = '0;
  logic [B-2:0] THRESHOLD = 11'd100;
  logic SPIKE_FLAG, BUSY;
  logic [15:0] SPIKE_TS;
  logic [B-2:0] PEAK_OUT;
  int checks = 0;
  int errors = 0;
  int cnt = 0, dead = 0, peak = 0, last_peak = 0, exp_ts = 0;
  int cap_mag = 0, cap_thr = 0, cap_idx = 0;
  bit in_event = 0, exp_flag = 0, cap_v = 0;

  spike_detect #(.BITSIZE(B), .REFRACT(R)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .THRESHOLD(THRESHOLD), .SPIKE_FLAG(SPIKE_FLAG), .SPIKE_TS(SPIKE_TS),
    .PEAK_OUT(PEAK_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic int magf(input int d);
    int m = d - 2048;
    if (m < 0) m = -m;
    return (m > 2047) ? 2047 : m;
  endfunction

  function automatic int pk(input int v);
`ifdef SPIKE_DETECT_PEAK_CAPTURE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model by one evaluation and compare.
  task automatic step(input bit en, input bit v, input int d, input int thr);
    EN = en;
    DATA_VALID = v;
    DATA_IN = 12'(d);
    THRESHOLD = 11'(thr);
    @(posedge CLK);
    #1;
    exp_flag = 0;
    if (!en) begin
      cnt = 0;
      in_event = 0;
      dead = 0;
    end else if (cap_v) begin
      if (dead > 0) dead--;
      else if (in_event) begin
        if (cap_mag > cap_thr) peak = (cap_mag > peak) ? cap_mag : peak;
        else begin
          in_event = 0;
          last_peak = peak;
          dead = R;
        end
      end else if (cap_mag > cap_thr) begin
        exp_flag = 1;
        exp_ts = cap_idx;
        in_event = 1;
        peak = cap_mag;
      end
    end
    cap_v = en && v;
    if (cap_v) begin
      cap_mag = magf(d);
      cap_thr = thr;
      cap_idx = cnt;
      cnt = (cnt + 1) % 65536;
    end
    chk("flag", 32'(SPIKE_FLAG), 32'(exp_flag));
    chk("ts", 32'(SPIKE_TS), 32'(exp_ts));
    chk("busy", 32'(BUSY), 32'(en && (in_event || dead > 0)));
    chk("peak", 32'(PEAK_OUT), 32'(pk(last_peak)));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 2048, 100);
  endtask

  task automatic pulse_rst();
    #2 RST = 1'b1;
    #1;
    chk("rst_flag", 32'(SPIKE_FLAG), 0);
    chk("rst_ts", 32'(SPIKE_TS), 0);
    chk("rst_peak", 32'(PEAK_OUT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    #2 RST = 1'b0;
    cnt = 0; in_event = 0; dead = 0; cap_v = 0; exp_flag = 0; exp_ts = 0; last_peak = 0; peak = 0;
  endtask

  initial begin
    #12;
    chk("init_flag", 32'(SPIKE_FLAG), 0);
    chk("init_ts", 32'(SPIKE_TS), 0);
    chk("init_peak", 32'(PEAK_OUT), 0);
    chk("init_busy", 32'(BUSY), 0);
    RST = 1'b0;
    step(1, 0, 2048, 100);
    step(1, 1, 2048, 100);
    step(1, 1, 2198, 100);
    step(1, 1, 2048, 100);
    chk("pos_flag", 32'(SPIKE_FLAG), 1);
    chk("pos_ts", 32'(SPIKE_TS), 1);
    quiet(6);
    chk("pos_peak", 32'(PEAK_OUT), 32'(pk(150)));
    step(1, 1, 1948, 100);
    step(1, 1, 2048, 100);
    chk("bound_noflag", 32'(SPIKE_FLAG), 0);
    step(1, 1, 1947, 100);
    step(1, 1, 2048, 100);
    chk("neg_flag", 32'(SPIKE_FLAG), 1);
    quiet(6);
    chk("neg_peak", 32'(PEAK_OUT), 32'(pk(101)));
    step(1, 1, 0, 100);
    step(1, 1, 2048, 100);
    chk("zero_flag", 32'(SPIKE_FLAG), 1);
    quiet(6);
    chk("zero_peak", 32'(PEAK_OUT), 32'(pk(2047)));
    step(1, 1, 2200, 100);
    step(1, 1, 2048, 100);
    for (int i = 0; i < 3; i++) step(1, 1, 2200, 100);
    step(1, 1, 2048, 100);
    chk("refr_busy", 32'(BUSY), 1);
    step(1, 1, 2200, 100);
    chk("refr_noflag", 32'(SPIKE_FLAG), 0);
    step(1, 1, 2048, 100);
    chk("refr_flag2", 32'(SPIKE_FLAG), 1);
    quiet(6);
    step(1, 1, 2200, 100);
    step(1, 1, 2300, 100);
    step(1, 1, 2250, 100);
    step(1, 1, 2048, 100);
    step(1, 1, 2048, 100);
    quiet(6);
    chk("multi_peak", 32'(PEAK_OUT), 32'(pk(252)));
    step(1, 1, 2400, 100);
    step(1, 1, 2048, 100);
    step(1, 1, 2048, 100);
    chk("dead_busy", 32'(BUSY), 1);
    pulse_rst();
    for (int i = 0; i < 3; i++) step(1, 1, 2048, 100);
    step(1, 1, 2500, 100);
    step(1, 0, 2048, 100);
    chk("post_rst_ts", 32'(SPIKE_TS), 3);
    quiet(6);
    step(1, 0, 2048, 100);
    step(0, 1, 2500, 100);
    step(1, 1, 2500, 100);
    step(1, 0, 2048, 100);
    chk("reen_flag", 32'(SPIKE_FLAG), 1);
    chk("reen_ts", 32'(SPIKE_TS), 0);
    quiet(6);
    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                      : 2048 + int'($urandom_range(0, 600)) - 300;
      step($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), d, int'($urandom_range(50, 200)));
    end
    step(0, 0, 2048, 100);
    for (int i = 0; i < 65536; i++) step(1, 1, 2048, 100);
    step(1, 1, 2300, 100);
    step(1, 0, 2048, 100);
    chk("wrap_flag", 32'(SPIKE_FLAG), 1);
    chk("wrap_ts", 32'(SPIKE_TS), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
